// File: rtl/barrel_shift_feeder.sv
// barrel_shift_feeder
//   Command front-end for the 8-bit rotate-right barrel shifter. Buffers
//   {operand, amount} commands in a small FIFO, drives the head entry to the
//   shifter from storage registers, and captures the shifter result into a
//   registered output stage with valid/ready handshakes on both sides.
//
// Ports
//   clk_amisha        single clock, rising edge
//   rst_n_amisha      asynchronous active-low reset
//   in_valid_amisha   upstream command valid
//   in_ready_amisha   FIFO has room (registered-state only)
//   in_a_amisha       operand to rotate
//   in_amt_amisha     rotate-right amount
//   sh_a_amisha       operand to the shifter (zero when FIFO empty)
//   sh_amt_amisha     amount to the shifter (zero when FIFO empty)
//   sh_y_amisha       shifter result
//   out_valid_amisha  result register holds a valid result
//   out_ready_amisha  downstream accepts the result
//   out_data_amisha   rotated result
//   out_amt_amisha    amount that produced out_data_amisha
//   count_amisha      FIFO occupancy, 0..DEPTH

module barrel_shift_feeder #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk_amisha,
    input  logic          rst_n_amisha,
    input  logic          in_valid_amisha,
    output logic          in_ready_amisha,
    input  logic [7:0]    in_a_amisha,
    input  logic [2:0]    in_amt_amisha,
    output logic [7:0]    sh_a_amisha,
    output logic [2:0]    sh_amt_amisha,
    input  logic [7:0]    sh_y_amisha,
    output logic          out_valid_amisha,
    input  logic          out_ready_amisha,
    output logic [7:0]    out_data_amisha,
    output logic [2:0]    out_amt_amisha,
    output logic [CW-1:0] count_amisha
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_a   [DEPTH];
    logic [2:0]    mem_amt [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic [2:0]    out_amt_q;
    logic          not_empty;
    logic          push;
    logic          pop;

    assign not_empty       = (count_q != '0);
    assign in_ready_amisha = (count_q != CW'(DEPTH));
    assign push            = in_valid_amisha & in_ready_amisha;
    // Pop whenever the output register is free or being emptied this cycle.
    assign pop             = not_empty & (~out_valid_q | out_ready_amisha);

    // Head is read straight from storage so nothing on in_* reaches sh_*.
    assign sh_a_amisha   = not_empty ? mem_a[rd_ptr]   : 8'h00;
    assign sh_amt_amisha = not_empty ? mem_amt[rd_ptr] : 3'o0;

    assign count_amisha     = count_q;
    assign out_valid_amisha = out_valid_q;
    assign out_data_amisha  = out_data_q;
    assign out_amt_amisha   = out_amt_q;

    // Storage needs no reset: it is only observed while count_q says valid.
    always_ff @(posedge clk_amisha) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a_amisha;
            mem_amt[wr_ptr] <= in_amt_amisha;
        end
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_amt_q   <= 3'o0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sh_y_amisha;
            out_amt_q   <= sh_amt_amisha;
        end else if (out_ready_amisha) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
